// File: rtl/bitserial_addsub_ctrl_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
package bitserial_addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bitserial_addsub_ctrl_if.sv
// Request/result bus of the bit-serial add/subtract engine.
// Both sides use valid/ready: a transfer happens on a rising edge where valid
// and ready are both high; valid, once raised, holds its payload stable until
// that transfer.
interface bitserial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             sub_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             overflow_o;
  logic             busy_o;

  modport slave (
    input  req_valid_i, a_i, b_i, sub_i, res_ready_i,
    output req_ready_o, res_valid_o, sum_o, carry_o, overflow_o, busy_o
  );

  modport master (
    output req_valid_i, a_i, b_i, sub_i, res_ready_i,
    input  req_ready_o, res_valid_o, sum_o, carry_o, overflow_o, busy_o
  );
endinterface

// File: rtl/bitserial_addsub_ctrl_fulladder.sv
// Single-bit full adder, time-shared by the serial engine.
module bitserial_addsub_ctrl_fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic carry_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i ^ carry_i;
  assign carry_o = (a_i & b_i) | (carry_i & (a_i ^ b_i));
endmodule

// File: rtl/bitserial_addsub_ctrl.sv
// Bit-serial add/subtract: one full adder stepped LSB-first over WIDTH cycles.
// Subtraction is A + ~B + 1, so carry_o=1 means no borrow.
module bitserial_addsub_ctrl
  import bitserial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  bitserial_addsub_ctrl_if.slave   bus,
  output state_t                   state_o
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cy_q, cy_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               res_valid_q, res_valid_d;
  logic               fa_sum, fa_carry;

  bitserial_addsub_ctrl_fulladder u_fa (
    .a_i     (a_q[0]),
    .b_i     (b_q[0]),
    .carry_i (cy_q),
    .sum_o   (fa_sum),
    .carry_o (fa_carry)
  );

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      cy_q        <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      cy_q        <= cy_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    cy_d        = cy_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    res_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          a_d     = bus.a_i;
          b_d     = bus.b_i ^ {WIDTH{bus.sub_i == OP_SUB}};
          cy_d    = bus.sub_i;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d = {fa_sum, sum_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = fa_carry;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // cy_q here is the carry into the MSB, fa_carry the carry out of it
          carry_d = fa_carry;
          ovf_d   = cy_q ^ fa_carry;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // result valid is registered, so it rises one edge after entering DONE
        if (res_valid_q && bus.res_ready_i) begin
          state_d = IDLE;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.res_valid_o = res_valid_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.sum_o       = sum_q;
  assign bus.carry_o     = carry_q;
  assign bus.overflow_o  = ovf_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_bitserial_addsub_ctrl.sv
// Directed and random bench for bitserial_addsub_ctrl with a result scoreboard.
module tb_bitserial_addsub_ctrl;
  import bitserial_addsub_ctrl_pkg::*;

  localparam int WIDTH = 8;
  localparam int RW    = WIDTH + 2;

  logic   clk;
  logic   arstn;
  state_t dbg_state;
  int     chk_cnt;
  int     pass_cnt;
  logic [RW-1:0] exp_q[$];

  bitserial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  bitserial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic sub);
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   full;
    logic             ovf;
    bx   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    ovf  = (a[WIDTH-1] == bx[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {ovf, full[WIDTH], full[WIDTH-1:0]};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, {29'd0, bus.req_ready_o, bus.res_valid_o, bus.busy_o}, 32'b100);
    chk({tag, "_data"}, {22'd0, bus.overflow_o, bus.carry_o, bus.sum_o}, 32'd0);
    chk({tag, "_state"}, {30'd0, dbg_state}, {30'd0, IDLE});
  endtask

  // driver: offer a request until accepted, push its expected result
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic sub, input logic [RW-1:0] exp);
    int n;
    bus.req_valid_i = 1'b1;
    bus.a_i         = a;
    bus.b_i         = b;
    bus.sub_i       = sub;
    n = 0;
    while (!bus.req_ready_o && n < 100) begin
      step();
      n++;
    end
    chk("req_accept_timeout", {31'd0, bus.req_ready_o}, 32'd1);
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    bus.req_valid_i = 1'b0;
    bus.a_i         = $urandom_range(0, 255);
    bus.b_i         = $urandom_range(0, 255);
    bus.sub_i       = $urandom_range(0, 1);
  endtask

  // consumer: wait for a result, stall, then take it and compare to scoreboard
  task automatic get_result(input string tag, input int stall);
    int n;
    logic [RW-1:0] snap;
    logic [RW-1:0] exp;
    bus.res_ready_i = 1'b0;
    n = 0;
    while (!bus.res_valid_o && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_valid_timeout"}, {31'd0, bus.res_valid_o}, 32'd1);
    snap = {bus.overflow_o, bus.carry_o, bus.sum_o};
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, "_hold"},
          {19'd0, bus.res_valid_o, bus.req_ready_o, bus.busy_o, bus.overflow_o, bus.carry_o, bus.sum_o},
          {19'd0, 1'b1, 1'b0, 1'b1, snap});
    end
    bus.res_ready_i = 1'b1;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, exp_q.size(), 32'd1);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    chk({tag, "_result"}, {22'd0, bus.overflow_o, bus.carry_o, bus.sum_o}, {22'd0, exp});
    step();
    bus.res_ready_i = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, bus.res_valid_o}, 32'd0);
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] ra, rb;
    logic rs;
    chk_cnt         = 0;
    pass_cnt        = 0;
    arstn           = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.sub_i       = OP_ADD;
    bus.res_ready_i = 1'b0;
    #23;
    chk_idle("reset");
    step();
    arstn = 1'b1;
    step();
    chk_idle("post_reset");

    // 1: latency and single-cycle valid
    bus.res_ready_i = 1'b1;
    send(8'h3C, 8'h15, OP_ADD, {1'b0, 1'b0, 8'h51});
    n = 0;
    while (!bus.res_valid_o && n < 50) begin
      step();
      n++;
    end
    chk("latency_edges", n, 32'd9);
    get_result("add_3c_15", 0);
    chk("idle_after_result", {31'd0, bus.req_ready_o}, 32'd1);

    // 2, 3: carry, overflow and borrow corners
    send(8'hFF, 8'h01, OP_ADD, {1'b0, 1'b1, 8'h00});
    get_result("add_ff_01", 0);
    send(8'h80, 8'h80, OP_ADD, {1'b1, 1'b1, 8'h00});
    get_result("add_80_80", 1);
    send(8'h7F, 8'hFF, OP_SUB, {1'b1, 1'b0, 8'h80});
    get_result("sub_7f_ff", 0);
    send(8'h05, 8'h03, OP_SUB, {1'b0, 1'b1, 8'h02});
    get_result("sub_05_03", 2);

    // 4: backpressure with a pending request held across DONE
    send(8'h3C, 8'h15, OP_ADD, {1'b0, 1'b0, 8'h51});
    bus.req_valid_i = 1'b1;
    bus.a_i         = 8'h0A;
    bus.b_i         = 8'h14;
    bus.sub_i       = OP_SUB;
    get_result("bp_first", 5);
    chk("bp_first_idle_ready", {30'd0, bus.req_valid_i, bus.req_ready_o}, 32'b11);
    send(8'h0A, 8'h14, OP_SUB, {1'b0, 1'b0, 8'hF6});
    chk("bp_accepted_busy", {31'd0, bus.busy_o}, 32'd1);
    get_result("bp_second", 0);

    // 5: asynchronous reset during the third CALC cycle
    send(8'h12, 8'h34, OP_ADD, {1'b0, 1'b0, 8'h46});
    step();
    step();
    chk("abort_in_calc", {30'd0, dbg_state}, {30'd0, CALC});
    #2;
    arstn = 1'b0;
    #1;
    chk_idle("abort");
    exp_q.delete();
    step();
    arstn = 1'b1;
    step();
    chk_idle("abort_release");
    send(8'h12, 8'h34, OP_ADD, {1'b0, 1'b0, 8'h46});
    get_result("after_abort", 0);

    // 6: random regression with random result stalls
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      rs = $urandom_range(0, 1);
      send(ra, rb, rs, model(ra, rb, rs));
      get_result("rand", $urandom_range(0, 3));
    end
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/bitserial_addsub_ctrl.md
Name: bitserial_addsub_ctrl

Overview:
Bit-serial add/subtract engine. It time-shares a single existing fulladder instance over WIDTH cycles to add or subtract two WIDTH-bit operands. The block owns operand shift registers, the carry flip-flop, the bit counter and the FSM that sequences the fulladder. It sits between a request producer and a result consumer, with valid/ready handshakes on both sides. It is the area-minimal alternative to a parallel ripple adder.

Parameters:
WIDTH, 8, operand/result width in bits; legal values are WIDTH >= 2.

Ports:
clk_i  in  1  clock; all state updates on the rising edge
arstn_i  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready; high only in IDLE
a_i  in  WIDTH  operand A, sampled only on request handshake
b_i  in  WIDTH  operand B, sampled only on request handshake
sub_i  in  1  0 = A+B, 1 = A-B; sampled on handshake
res_valid_o  out  1  result valid
res_ready_i  in  1  result ready
sum_o  out  WIDTH  result
carry_o  out  1  final carry out; for sub, 1 = no borrow
overflow_o  out  1  signed overflow
busy_o  out  1  high in CALC or DONE

Behaviour:
- Clocking and reset: one clock (clk_i). Reset arstn_i is asynchronous, active-low.
- Reset values: state=IDLE; req_ready_o=1; res_valid_o=0; busy_o=0; sum_o, carry_o, overflow_o, shift registers, carry flop and counter all 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i && req_ready_o: load A_sr<=a_i, B_sr<=b_i ^ {WIDTH{sub_i}}, cy<=sub_i, cnt<=0, go to CALC.
- CALC, once per cycle:
  - Drive fulladder with a=A_sr[0], b=B_sr[0], carry_i=cy.
  - Result register shifts right, with the sum bit entering the MSB.
  - A_sr and B_sr shift right; cy<=fulladder carry_o; cnt<=cnt+1.
  - On the cycle cnt==WIDTH-1: latch carry_o<=fulladder carry_o, overflow_o<=cy ^ fulladder carry_o (carry into MSB xor carry out of MSB), go to DONE.
- Latency: handshake on edge k gives res_valid_o=1 after edge k+WIDTH+1 (one load cycle plus WIDTH compute cycles).
- DONE:
  - res_valid_o=1; sum_o, carry_o and overflow_o are held stable.
  - On res_ready_i: go to IDLE with res_valid_o=0.
  - The next request can be accepted on the following cycle. There is no request/result overlap.
- Backpressure: res_valid_o is never withdrawn without a handshake, and outputs do not change while res_valid_o=1.
- Requests are ignored in CALC and DONE (req_ready_o=0). a_i/b_i/sub_i changing during CALC have no effect.
- Output visibility: sum_o shows partial shift contents during CALC. Consumers sample only with res_valid_o.
- Counter width is $clog2(WIDTH). Comparison is against WIDTH-1 only; the counter never wraps.
- Mid-operation reset: aborts immediately, all outputs go to reset values, no result is emitted. The first request after release is processed normally.
- Simultaneous events:
  - req_valid_i held high across DONE→IDLE: accepted on the first IDLE cycle.
  - res_ready_i high before DONE: no effect.
- busy_o = (state != IDLE).

Decomposition:
- Shared package holds:
  - state enum (IDLE, CALC, DONE) as typedef state_t;
  - op encoding constants OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-module: one instance of the existing fulladder. No other sub-modules; the FSM, counter and shift registers stay in this block.

Test Plan (all at WIDTH=8):
1. Add 8'h3C+8'h15, res_ready_i=1 → sum_o=8'h51, carry_o=0, overflow_o=0. res_valid_o rises exactly 9 edges after the accept edge and lasts one cycle.
2. Add 8'hFF+8'h01 → sum_o=8'h00, carry_o=1, overflow_o=0. Then add 8'h80+8'h80 → sum_o=8'h00, carry_o=1, overflow_o=1.
3. Sub 8'h7F−8'hFF → sum_o=8'h80, carry_o=0, overflow_o=1. Then sub 8'h05−8'h03 → sum_o=8'h02, carry_o=1, overflow_o=0.
4. Backpressure: hold res_ready_i=0 for 5 cycles in DONE while req_valid_i=1 with new operands → outputs stable, req_ready_o=0, busy_o=1. After res_ready_i=1, the queued request is accepted the next cycle and its result is correct.
5. Assert arstn_i=0 on the 3rd CALC cycle of 8'h12+8'h34, asynchronously between edges → all outputs go to 0 immediately with req_ready_o=1. After release, 8'h12+8'h34 gives 8'h46 with no stale carry.
6. Random regression: 1000 random a/b/sub with random res_ready_i stalls → sum/carry/overflow match the reference model and handshake protocol assertions hold.
